axi_rd_arbiter: RTL and testbench

- Shares one AXI4 read channel (AR/R) between two SRAM-like read requesters: the instruction fetch port and the data (load) port.
- Sits between the IF/MEM stages and the AXI bridge top.
- Tags each request with an ARID: 0 for instruction, 1 for data.
- Routes R beats back to the owner by RID and tracks outstanding reads per requester.

---
 rtl/axi_rd_arbiter.sv | 132 +++++++++++++
 tb/tb_axi_rd_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - shares one AXI4 read channel between instruction fetch and data load ports
// ARID 0 carries instruction reads, ARID 1 carries data reads; R beats are routed back by rid[0].
module axi_rd_arbiter #(
  parameter int MAX_OUTST = 2,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic [31:0]       inst_addr,
  input  logic [1:0]        inst_size,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic [31:0]       data_addr,
  input  logic [1:0]        data_size,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic [3:0]        arid,
  output logic [31:0]       araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [1:0]        arlock,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

  typedef enum logic {AR_IDLE, AR_SEND} ar_state_t;

  localparam logic [2:0] MAX_CNT = 3'(MAX_OUTST);

  ar_state_t  state, state_nxt;
  logic       last_grant_data;
  logic [2:0] inst_cnt, data_cnt;
  logic       inst_elig, data_elig;
  logic       grant_inst, grant_data;
  logic       unused_ok;

  assign unused_ok = ^{rresp, rlast, rid[3:1]};

  assign inst_elig = inst_req && (inst_cnt < MAX_CNT);
  assign data_elig = data_req && (data_cnt < MAX_CNT);

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    state_nxt  = state;
    grant_inst = 1'b0;
    grant_data = 1'b0;
    case (state)
      AR_IDLE: begin
        if (inst_elig && data_elig) begin
          grant_data = !last_grant_data;
          grant_inst = last_grant_data;
        end else begin
          grant_inst = inst_elig;
          grant_data = data_elig;
        end
        if (inst_elig || data_elig) state_nxt = AR_SEND;
      end
      AR_SEND: if (arready) state_nxt = AR_IDLE;
      default: state_nxt = AR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= AR_IDLE;
      last_grant_data <= 1'b0;
      arid            <= 4'd0;
      araddr          <= 32'd0;
      arsize          <= 3'd0;
      rready          <= 1'b0;
    end else begin
      state  <= state_nxt;
      rready <= 1'b1;
      if (grant_inst || grant_data) begin
        last_grant_data <= grant_data;
        arid            <= {3'b000, grant_data};
        araddr          <= grant_data ? data_addr : inst_addr;
        arsize          <= {1'b0, grant_data ? data_size : inst_size};
      end
    end
  end

  assign arvalid = (state == AR_SEND);
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  assign inst_addr_ok = arvalid && arready && !arid[0];
  assign data_addr_ok = arvalid && arready && arid[0];

  assign inst_data_ok = rvalid && rready && !rid[0];
  assign data_data_ok = rvalid && rready && rid[0];
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  // A beat with nothing outstanding leaves the counter at zero rather than wrapping.
  function automatic logic [2:0] cnt_next(input logic [2:0] cnt, input logic inc, input logic dec);
    case ({inc, dec})
      2'b10:   return cnt + 3'd1;
      2'b01:   return (cnt == 3'd0) ? cnt : cnt - 3'd1;
      default: return cnt;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      inst_cnt <= 3'd0;
      data_cnt <= 3'd0;
    end else begin
      inst_cnt <= cnt_next(inst_cnt, inst_addr_ok, inst_data_ok);
      data_cnt <= cnt_next(data_cnt, data_addr_ok, data_data_ok);
      if (inst_data_ok) assert (inst_cnt != 3'd0) else $error("inst R beat with no outstanding read");
      if (data_data_ok) assert (data_cnt != 3'd0) else $error("data R beat with no outstanding read");
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - directed and randomized checks of axi_rd_arbiter against a transaction-level model
module tb_axi_rd_arbiter;
  localparam int MAX_OUTST = 2;
  localparam int DATA_W    = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              inst_req, data_req;
  logic [31:0]       inst_addr, data_addr;
  logic [1:0]        inst_size, data_size;
  logic              inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [DATA_W-1:0] inst_rdata, data_rdata;
  logic [3:0]        arid;
  logic [31:0]       araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst, arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arvalid, arready;
  logic [3:0]        rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast, rvalid, rready;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.MAX_OUTST(MAX_OUTST), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_addr(data_addr), .data_size(data_size),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: the one AR request currently presented (-1 none, 0 inst, 1 data),
  // who won the last grant, reads in flight per requester, and whether R is open.
  int          m_pend;
  logic [31:0] m_addr;
  logic [1:0]  m_size;
  int          m_last;
  int          m_cnt[2];
  bit          m_rready;

  bit          ok_i, ok_d, dok_i, dok_d;
  logic [3:0]  seen_arid;
  logic [31:0] seen_araddr;
  logic [31:0] seen_irdata, seen_drdata;
  int          arid_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit e_iok, e_dok, e_idok, e_ddok, ei, ed;
    #2;
    e_iok  = (m_pend == 0) && arready;
    e_dok  = (m_pend == 1) && arready;
    e_idok = rvalid && m_rready && !rid[0];
    e_ddok = rvalid && m_rready && rid[0];
    chk("arvalid", 64'(arvalid), 64'(m_pend >= 0));
    if (m_pend >= 0) begin
      chk("arid", 64'(arid), 64'(m_pend));
      chk("araddr", 64'(araddr), 64'(m_addr));
      chk("arsize", 64'(arsize), 64'({1'b0, m_size}));
    end
    chk("rready", 64'(rready), 64'(m_rready));
    chk("inst_addr_ok", 64'(inst_addr_ok), 64'(e_iok));
    chk("data_addr_ok", 64'(data_addr_ok), 64'(e_dok));
    chk("inst_data_ok", 64'(inst_data_ok), 64'(e_idok));
    chk("data_data_ok", 64'(data_data_ok), 64'(e_ddok));
    if (e_idok) chk("inst_rdata", 64'(inst_rdata), 64'(rdata));
    if (e_ddok) chk("data_rdata", 64'(data_rdata), 64'(rdata));
    chk("ar_const", 64'({arlen, arburst, arlock, arcache, arprot}), 64'({8'd0, 2'b01, 2'b00, 4'd0, 3'd0}));
    ok_i = inst_addr_ok; ok_d = data_addr_ok; dok_i = inst_data_ok; dok_d = data_data_ok;
    seen_irdata = inst_rdata; seen_drdata = data_rdata;
    if (e_iok || e_dok) begin
      seen_arid = arid; seen_araddr = araddr;
      arid_log.push_back(int'(arid));
    end
    if (reset) begin
      m_pend = -1; m_last = 0; m_cnt = '{0, 0}; m_rready = 1'b0;
    end else begin
      ei = inst_req && (m_cnt[0] < MAX_OUTST);
      ed = data_req && (m_cnt[1] < MAX_OUTST);
      if (m_pend < 0 && (ei || ed)) begin
        m_pend = (ei && ed) ? 1 - m_last : (ed ? 1 : 0);
        m_last = m_pend;
        m_addr = m_pend == 1 ? data_addr : inst_addr;
        m_size = m_pend == 1 ? data_size : inst_size;
      end else if (e_iok || e_dok) begin
        m_pend = -1;
      end
      m_cnt[0] += int'(e_iok) - int'(e_idok);
      m_cnt[1] += int'(e_dok) - int'(e_ddok);
      m_rready = 1'b1;
    end
    @(posedge clk); #1;
    if (e_iok) inst_req = 1'b0;
    if (e_dok) data_req = 1'b0;
    rvalid = 1'b0;
  endtask

  task automatic drain();
    inst_req = 1'b0; data_req = 1'b0;
    for (int k = 0; k < 40 && (m_cnt[0] + m_cnt[1]) > 0; k++) begin
      if (m_pend < 0) begin
        rvalid = 1'b1;
        rid    = (m_cnt[1] > 0) ? 4'd1 : 4'd0;
        rdata  = $urandom;
      end
      arready = 1'b1;
      tick();
    end
    chk("drained", 64'(m_cnt[0] + m_cnt[1]), 64'd0);
  endtask

  initial begin
    int n_i, n_d;
    int exp_seq[4];
    reset = 1'b1; inst_req = 1'b0; data_req = 1'b0;
    inst_addr = 32'd0; data_addr = 32'd0; inst_size = 2'b10; data_size = 2'b10;
    arready = 1'b0; rid = 4'd0; rdata = '0; rresp = 2'b00; rlast = 1'b1; rvalid = 1'b0;
    m_pend = -1; m_last = 0; m_cnt = '{0, 0}; m_rready = 1'b0;
    @(posedge clk); #1;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Single instruction read.
    inst_req = 1'b1; inst_addr = 32'h1c00_0000; inst_size = 2'b10; arready = 1'b1;
    tick();
    chk("t1_no_ok_at_T", 64'(ok_i), 64'd0);
    tick();
    chk("t1_ok_at_T1", 64'(ok_i), 64'd1);
    chk("t1_arid", 64'(seen_arid), 64'd0);
    chk("t1_araddr", 64'(seen_araddr), 64'h1c00_0000);
    tick();
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h0280_0404;
    tick();
    chk("t1_data_ok", 64'(dok_i), 64'd1);
    chk("t1_rdata", 64'(seen_irdata), 64'h0280_0404);

    // Both requesting: grants alternate starting with data.
    arid_log.delete();
    for (int k = 0; k < 8; k++) begin
      if (!inst_req) begin inst_req = 1'b1; inst_addr = $urandom; end
      if (!data_req) begin data_req = 1'b1; data_addr = $urandom; end
      tick();
    end
    exp_seq = '{1, 0, 1, 0};
    chk("alt_count", 64'(arid_log.size()), 64'd4);
    for (int k = 0; k < 4 && k < arid_log.size(); k++) chk("alt_arid", 64'(arid_log[k]), 64'(exp_seq[k]));
    drain();

    // Outstanding limit blocks only the saturated requester.
    n_i = 0; n_d = 0;
    for (int k = 0; k < 10; k++) begin
      data_req = 1'b1;
      if (k >= 4 && !inst_req) begin inst_req = 1'b1; inst_addr = $urandom; end
      tick();
      n_i += int'(ok_i); n_d += int'(ok_d);
    end
    chk("max_data_grants", 64'(n_d), 64'(MAX_OUTST));
    chk("max_inst_grants", 64'(n_i), 64'(MAX_OUTST));
    inst_req = 1'b0;
    rvalid = 1'b1; rid = 4'd1; rdata = $urandom;
    tick();
    n_d = 0;
    for (int k = 0; k < 4; k++) begin
      data_req = 1'b1;
      tick();
      n_d += int'(ok_d);
    end
    chk("max_unblocked", 64'(n_d), 64'd1);
    drain();

    // Out-of-order return across IDs.
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin inst_req = 1'b1; data_req = 1'b1; end
      tick();
    end
    rvalid = 1'b1; rid = 4'd1; rdata = 32'hAAAA_0001;
    tick();
    chk("ooo_data_ok", 64'(dok_d), 64'd1);
    chk("ooo_data_rdata", 64'(seen_drdata), 64'hAAAA_0001);
    rvalid = 1'b1; rid = 4'd0; rdata = 32'hBBBB_0000;
    tick();
    chk("ooo_inst_ok", 64'(dok_i), 64'd1);
    chk("ooo_inst_rdata", 64'(seen_irdata), 64'hBBBB_0000);
    chk("ooo_cnt", 64'(m_cnt[0] + m_cnt[1]), 64'd0);

    // AR stall: payload held while arready is low.
    inst_req = 1'b1; inst_addr = 32'h0000_1234; arready = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_no_ok", 64'(ok_i), 64'd0);
    end
    arready = 1'b1;
    tick();
    chk("stall_ok", 64'(ok_i), 64'd1);
    drain();

    // Same-cycle accept and return on one counter, then reset mid-send.
    inst_req = 1'b1; arready = 1'b1;
    tick(); tick();
    inst_req = 1'b1; inst_addr = 32'h0000_5678;
    tick();
    rvalid = 1'b1; rid = 4'd0; rdata = $urandom;
    tick();
    chk("same_cycle_ok", 64'({ok_i, dok_i}), 64'b11);
    chk("same_cycle_cnt", 64'(m_cnt[0]), 64'd1);
    inst_req = 1'b1; arready = 1'b0;
    tick(); tick();
    reset = 1'b1; inst_req = 1'b0;
    tick(); tick();
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_rready", 64'(rready), 64'd0);
    reset = 1'b0;
    tick();

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      if (!inst_req && $urandom_range(0, 2) == 0) begin
        inst_req = 1'b1; inst_addr = $urandom; inst_size = 2'($urandom_range(0, 2));
      end
      if (!data_req && $urandom_range(0, 2) == 0) begin
        data_req = 1'b1; data_addr = $urandom; data_size = 2'($urandom_range(0, 2));
      end
      arready = ($urandom_range(0, 3) != 0);
      if ((m_cnt[0] + m_cnt[1]) > 0 && $urandom_range(0, 1) == 1) begin
        rvalid = 1'b1;
        if (m_cnt[0] == 0) rid = 4'd1;
        else if (m_cnt[1] == 0) rid = 4'd0;
        else rid = 4'($urandom_range(0, 1));
        rdata = $urandom;
      end
      tick();
    end
    for (int k = 0; k < 8; k++) begin
      arready = 1'b1;
      tick();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
